// File: rtl/mem_responder.sv
// mem_responder: single-port word memory on the memory side of a val/rdy request/response link.
// Responses return in acceptance order through a small FIFO; interval counters throttle both sides.
module mem_responder #(
  parameter int unsigned p_opaq_bits       = 8,
  parameter int unsigned p_addr_bits       = 32,
  parameter int unsigned p_data_bits       = 32,
  parameter int unsigned p_mem_words       = 256,
  parameter int unsigned p_fifo_depth      = 2,
  parameter int unsigned p_send_intv_delay = 1,
  parameter int unsigned p_recv_intv_delay = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic                     req_op,
  input  logic [p_opaq_bits-1:0]   req_opaque,
  input  logic [p_addr_bits-1:0]   req_addr,
  input  logic [p_data_bits-1:0]   req_data,
  input  logic [p_data_bits/8-1:0] req_strb,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic                     resp_op,
  output logic [p_opaq_bits-1:0]   resp_opaque,
  output logic [p_addr_bits-1:0]   resp_addr,
  output logic [p_data_bits-1:0]   resp_data,
  input  logic                     init_en,
  input  logic [p_addr_bits-1:0]   init_addr,
  input  logic [p_data_bits-1:0]   init_data
);

  localparam int unsigned IdxW     = $clog2(p_mem_words);
  localparam int unsigned PtrW     = (p_fifo_depth > 1) ? $clog2(p_fifo_depth) : 1;
  localparam int unsigned CntW     = $clog2(p_fifo_depth + 1);
  localparam int unsigned NumBytes = p_data_bits / 8;
  localparam logic [31:0] RecvReload = 32'(p_recv_intv_delay - 1);
  localparam logic [31:0] SendReload = 32'(p_send_intv_delay - 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(p_fifo_depth - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(p_fifo_depth);

  // Storage
  logic [p_data_bits-1:0] mem [p_mem_words];

  logic                   fifo_op     [p_fifo_depth];
  logic [p_opaq_bits-1:0] fifo_opaque [p_fifo_depth];
  logic [p_addr_bits-1:0] fifo_addr   [p_fifo_depth];
  logic [p_data_bits-1:0] fifo_data   [p_fifo_depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     recv_cnt_q, recv_cnt_d;
  logic [31:0]     send_cnt_q, send_cnt_d;

  logic            fifo_full, fifo_empty;
  logic            req_fire, resp_fire;
  logic [IdxW-1:0] req_idx, init_idx;
  logic [p_data_bits-1:0] rd_word;

  // Word index only; byte offset and bits above the array size are dropped so accesses wrap.
  assign req_idx  = req_addr[IdxW+1:2];
  assign init_idx = init_addr[IdxW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[p_addr_bits-1:IdxW+2],
                              init_addr[1:0], init_addr[p_addr_bits-1:IdxW+2]};

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);

  assign req_rdy   = rst_n && !fifo_full && (recv_cnt_q == '0);
  assign resp_val  = !fifo_empty && (send_cnt_q == '0);
  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;

  assign rd_word = mem[req_idx];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // The request write is issued after the init write so it wins on its enabled byte lanes.
  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_idx] <= init_data;
    end
    if (req_fire && req_op) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (req_strb[b]) begin
          mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      fifo_op[wr_ptr_q]     <= req_op;
      fifo_opaque[wr_ptr_q] <= req_opaque;
      fifo_addr[wr_ptr_q]   <= req_addr;
      fifo_data[wr_ptr_q]   <= req_op ? '0 : rd_word;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (req_fire) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (resp_fire) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({req_fire, resp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    recv_cnt_d = recv_cnt_q;
    send_cnt_d = send_cnt_q;

    if (req_fire) begin
      recv_cnt_d = RecvReload;
    end else if (recv_cnt_q != '0) begin
      recv_cnt_d = recv_cnt_q - 32'd1;
    end

    if (resp_fire) begin
      send_cnt_d = SendReload;
    end else if (send_cnt_q != '0) begin
      send_cnt_d = send_cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      recv_cnt_q <= '0;
      send_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      recv_cnt_q <= recv_cnt_d;
      send_cnt_q <= send_cnt_d;
    end
  end

  assign resp_op     = fifo_op[rd_ptr_q];
  assign resp_opaque = fifo_opaque[rd_ptr_q];
  assign resp_addr   = fifo_addr[rd_ptr_q];
  assign resp_data   = fifo_data[rd_ptr_q];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed cases plus random traffic, checked by a queue scoreboard
// fed from a word-array reference model; a second instance checks the interval throttling.
module tb_mem_responder;
  localparam int unsigned Words = 256;
  localparam int unsigned Depth = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_val = 0, req_op = 0, resp_rdy = 0, init_en = 0;
  logic [7:0]  req_opaque = 0;
  logic [31:0] req_addr = 0, req_data = 0, init_addr = 0, init_data = 0;
  logic [3:0]  req_strb = 0;
  logic        req_rdy, resp_val, resp_op;
  logic [7:0]  resp_opaque;
  logic [31:0] resp_addr, resp_data;

  logic        s_req_val = 0, s_resp_rdy = 1;
  logic        s_req_rdy, s_resp_val, s_resp_op;
  logic [7:0]  s_resp_opaque;
  logic [31:0] s_resp_addr, s_resp_data;

  mem_responder #(
    .p_opaq_bits(8), .p_addr_bits(32), .p_data_bits(32), .p_mem_words(Words),
    .p_fifo_depth(Depth), .p_send_intv_delay(1), .p_recv_intv_delay(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_opaque(req_opaque),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_opaque(resp_opaque),
    .resp_addr(resp_addr), .resp_data(resp_data),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data)
  );

  mem_responder #(
    .p_opaq_bits(8), .p_addr_bits(32), .p_data_bits(32), .p_mem_words(64),
    .p_fifo_depth(2), .p_send_intv_delay(3), .p_recv_intv_delay(3)
  ) u_slow (
    .clk(clk), .rst_n(rst_n),
    .req_val(s_req_val), .req_rdy(s_req_rdy), .req_op(1'b0), .req_opaque(8'h00),
    .req_addr(32'h0), .req_data(32'h0), .req_strb(4'h0),
    .resp_val(s_resp_val), .resp_rdy(s_resp_rdy), .resp_op(s_resp_op),
    .resp_opaque(s_resp_opaque), .resp_addr(s_resp_addr), .resp_data(s_resp_data),
    .init_en(1'b0), .init_addr(32'h0), .init_data(32'h0)
  );

  typedef struct {
    logic        op;
    logic [7:0]  opq;
    logic [31:0] addr;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] model_mem [Words];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pushed_now = 0;
  bit          mon_en = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % Words);
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // One cycle of stimulus; the model is updated for the edge that follows.
  task automatic drive(input bit v, input bit op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [7:0] opq,
                       input bit rr, input bit ie, input logic [31:0] ia,
                       input logic [31:0] id, output bit acc);
    resp_t       e;
    logic [31:0] w;
    @(negedge clk);
    req_val = v; req_op = op; req_addr = addr; req_data = data; req_strb = strb;
    req_opaque = opq; resp_rdy = rr; init_en = ie; init_addr = ia; init_data = id;
    #1;
    check("req_rdy", {31'd0, req_rdy}, {31'd0, sb.size() < Depth});
    acc = v && req_rdy;
    if (acc) begin
      e.op = op; e.opq = opq; e.addr = addr;
      e.data = op ? 32'd0 : model_mem[widx(addr)];
      sb.push_back(e);
      pushed_now = 1;
    end
    if (ie) model_mem[widx(ia)] = id;
    if (acc && op) begin
      w = model_mem[widx(addr)];
      for (int k = 0; k < 4; k++) if (strb[k]) w[8*k +: 8] = data[8*k +: 8];
      model_mem[widx(addr)] = w;
    end
  endtask

  task automatic req(input bit op, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [7:0] opq, input bit rr);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      drive(1'b1, op, addr, data, strb, opq, rr, 1'b0, 32'd0, 32'd0, acc);
      n++;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL req_accept_timeout: got no accept, expected accept within 20 cycles");
    end
    @(posedge clk);
    #1;
    req_val = 0;
    init_en = 0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 8'h00, 1'b1, 1'b0,
                                      32'd0, 32'd0, acc);
  endtask

  // Monitor: every response the DUT hands over is matched against the scoreboard head.
  resp_t mon_e;
  int    mon_occ;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst_n) begin
        mon_occ = sb.size() - (pushed_now ? 1 : 0);
        check("resp_val", {31'd0, resp_val}, {31'd0, mon_occ > 0});
        if (resp_val && resp_rdy) begin
          if (mon_occ == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_extra: got response opaque 0x%02h, expected none", resp_opaque);
          end else begin
            mon_e = sb.pop_front();
            check("resp_op", {31'd0, resp_op}, {31'd0, mon_e.op});
            check("resp_opaque", {24'd0, resp_opaque}, {24'd0, mon_e.opq});
            check("resp_addr", resp_addr, mon_e.addr);
            check("resp_data", resp_data, mon_e.data);
          end
        end
      end
      pushed_now = 0;
    end
  end

  bit          acc;
  int          k;
  bit          r_v, r_op, r_rr, r_ie;
  logic [31:0] r_addr, r_data, r_ia;
  logic [3:0]  r_strb;
  int          acc_t[$];
  int          snd_t[$];

  initial begin
    // Reset state
    #12;
    check("reset_req_rdy", {31'd0, req_rdy}, 32'd0);
    check("reset_resp_val", {31'd0, resp_val}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;

    // Preload the whole array through the init port.
    for (int i = 0; i < int'(Words); i++)
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 8'h00, 1'b1, 1'b1, 32'(i * 4), $urandom, acc);

    // Init then read with one-cycle response latency.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 8'h00, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, acc);
    req(1'b0, 32'h10, 32'd0, 4'h0, 8'h5A, 1'b1);
    idle(2);

    // Byte-strobed write over a preloaded word.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 8'h00, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD, acc);
    req(1'b1, 32'h20, 32'h11223344, 4'b0101, 8'h01, 1'b1);
    req(1'b0, 32'h20, 32'd0, 4'h0, 8'h02, 1'b1);
    idle(2);

    // Back-pressure: only Depth requests fit while resp_rdy is low.
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'd0, 4'h0, 8'(k), 1'b0, 1'b0, 32'd0, 32'd0,
            acc);
      if (acc) k++;
    end
    check("fifo_full_accepts", 32'(k), 32'd2);
    idle(4);

    // Address wrap.
    req(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 8'h10, 1'b1);
    req(1'b0, 32'h000, 32'd0, 4'h0, 8'h11, 1'b1);
    idle(2);

    // Reset with two responses queued.
    req(1'b1, 32'h100, 32'h13572468, 4'hF, 8'h77, 1'b0);
    req(1'b0, 32'h104, 32'd0, 4'h0, 8'h78, 1'b0);
    #2;
    rst_n = 0;
    #1;
    check("midrst_resp_val", {31'd0, resp_val}, 32'd0);
    check("midrst_req_rdy", {31'd0, req_rdy}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    req(1'b0, 32'h100, 32'd0, 4'h0, 8'h79, 1'b1);
    idle(2);

    // Random traffic with back-pressure and init collisions.
    for (int i = 0; i < 500; i++) begin
      r_v = ($urandom_range(0, 9) < 7);
      r_op = $urandom_range(0, 1) == 1;
      r_addr = $urandom_range(0, 'hFFF);
      r_data = $urandom;
      r_strb = 4'($urandom_range(0, 15));
      r_rr = ($urandom_range(0, 9) < 7);
      r_ie = ($urandom_range(0, 9) < 2);
      r_ia = ($urandom_range(0, 2) == 0) ? r_addr : 32'($urandom_range(0, 'hFFF));
      drive(r_v, r_op, r_addr, r_data, r_strb, 8'($urandom), r_rr, r_ie, r_ia, $urandom, acc);
    end

    // Drain.
    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    check("drain_empty", 32'(sb.size()), 32'd0);
    idle(2);

    // Interval throttling on the delay-3 instance.
    @(negedge clk);
    s_req_val = 1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (s_req_val && s_req_rdy) acc_t.push_back(c);
      if (s_resp_val && s_resp_rdy) snd_t.push_back(c);
      @(negedge clk);
    end
    s_req_val = 0;
    check("slow_accept_count", 32'(acc_t.size()), 32'd10);
    check("slow_send_count", 32'(snd_t.size()), 32'd10);
    if (acc_t.size() > 0 && snd_t.size() > 0)
      check("slow_first_latency", 32'(snd_t[0] - acc_t[0]), 32'd1);
    for (int i = 1; i < acc_t.size(); i++)
      check("slow_accept_gap", 32'(acc_t[i] - acc_t[i-1]), 32'd3);
    for (int i = 1; i < snd_t.size(); i++)
      check("slow_send_gap", 32'(snd_t[i] - snd_t[i-1]), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
